// File: rtl/decode_issue_stage.sv
// Decode / register-read stage feeding the ALU: decodes MIPS fields, reads the
// register file with writeback bypass, and stalls on scoreboard hazards.
module decode_issue_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      instr_valid,
  input  logic [31:0]               instr,
  output logic                      instr_ready,
  output logic                      ex_valid,
  input  logic                      ex_ready,
  output logic [5:0]                ex_opcode,
  output logic [5:0]                ex_funct,
  output logic [DATA_WIDTH-1:0]     ex_busA,
  output logic [DATA_WIDTH-1:0]     ex_busB,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      wb_en,
  input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0]     wb_data
);

  localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic [DATA_WIDTH-1:0]     regs [NUM_REGS];
  logic [NUM_REGS-1:0]       pend;
  logic [NUM_REGS-1:0]       wb_clear;
  logic [NUM_REGS-1:0]       eff_pend;
  logic [NUM_REGS-1:0]       dest_set;

  logic [5:0]                opcode;
  logic [5:0]                funct;
  logic [REG_ADDR_WIDTH-1:0] rs;
  logic [REG_ADDR_WIDTH-1:0] rt;
  logic [REG_ADDR_WIDTH-1:0] rd;
  logic [REG_ADDR_WIDTH-1:0] dest;
  logic [DATA_WIDTH-1:0]     imm_ext;
  logic [DATA_WIDTH-1:0]     rs_val;
  logic [DATA_WIDTH-1:0]     rt_val;
  logic [DATA_WIDTH-1:0]     bus_b;
  logic                      is_rtype;
  logic                      hazard;
  logic                      slot_free;
  logic                      issue;

  assign opcode   = instr[31:26];
  assign funct    = instr[5:0];
  assign rs       = instr[21 +: REG_ADDR_WIDTH];
  assign rt       = instr[16 +: REG_ADDR_WIDTH];
  assign rd       = instr[11 +: REG_ADDR_WIDTH];
  assign imm_ext  = {{(DATA_WIDTH-16){instr[15]}}, instr[15:0]};
  assign is_rtype = (opcode == OP_RTYPE);

  always_comb begin
    dest = '0;
    if (is_rtype)
      dest = rd;
    else if (opcode == OP_ADDI)
      dest = rt;
  end

  // A writeback in the same cycle retires the pending entry, so it must not stall.
  always_comb begin
    wb_clear = '0;
    if (wb_en)
      wb_clear[wb_addr] = 1'b1;
  end

  assign eff_pend = pend & ~wb_clear;

  always_comb begin
    hazard = 1'b0;
    if (instr_valid) begin
      if (eff_pend[rs])
        hazard = 1'b1;
      if (is_rtype && eff_pend[rt])
        hazard = 1'b1;
      if ((dest != '0) && eff_pend[dest])
        hazard = 1'b1;
    end
  end

  assign slot_free   = !ex_valid || ex_ready;
  assign instr_ready = rst && slot_free && !hazard;
  assign issue       = instr_valid && instr_ready;

  always_comb begin
    if (rs == '0)
      rs_val = '0;
    else if (wb_en && (wb_addr == rs))
      rs_val = wb_data;
    else
      rs_val = regs[rs];
  end

  always_comb begin
    if (rt == '0)
      rt_val = '0;
    else if (wb_en && (wb_addr == rt))
      rt_val = wb_data;
    else
      rt_val = regs[rt];
  end

  assign bus_b = is_rtype ? rt_val : imm_ext;

  always_comb begin
    dest_set = '0;
    if (issue && (dest != '0))
      dest_set[dest] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid  <= 1'b0;
      ex_opcode <= '0;
      ex_funct  <= '0;
      ex_busA   <= '0;
      ex_busB   <= '0;
      ex_rd     <= '0;
    end else if (issue) begin
      ex_valid  <= 1'b1;
      ex_opcode <= opcode;
      ex_funct  <= funct;
      ex_busA   <= rs_val;
      ex_busB   <= bus_b;
      ex_rd     <= dest;
    end else if (ex_ready) begin
      ex_valid  <= 1'b0;
    end
  end

  // Set wins over clear; bit 0 is forced low so r0 can never stall anything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      pend <= '0;
    else
      pend <= ((pend & ~wb_clear) | dest_set) & ~{{(NUM_REGS-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (wb_en && (wb_addr != '0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: a behavioural register/pending model
// checked every cycle, plus literal expectations from the worked examples.
module tb_decode_issue_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_ready;
  logic        ex_valid;
  logic        ex_ready = 1'b1;
  logic [5:0]  ex_opcode;
  logic [5:0]  ex_funct;
  logic [31:0] ex_busA;
  logic [31:0] ex_busB;
  logic [4:0]  ex_rd;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;

  int n_tests = 0;
  int n_fail  = 0;

  decode_issue_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_opcode(ex_opcode), .ex_funct(ex_funct),
    .ex_busA(ex_busA), .ex_busB(ex_busB), .ex_rd(ex_rd),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  // Behavioural model: architectural register values and set of in-flight destinations.
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  logic        m_valid;
  logic [5:0]  m_opcode, m_funct;
  logic [31:0] m_busA, m_busB;
  logic [4:0]  m_rd;

  function automatic int dest_of(input logic [31:0] w);
    if (w[31:26] == 6'd0) return int'(w[15:11]);
    if (w[31:26] == 6'd8) return int'(w[20:16]);
    return 0;
  endfunction

  function automatic bit busy_now(input int r);
    if (r == 0) return 1'b0;
    if (wb_en && int'(wb_addr) == r) return 1'b0;
    return m_busy[r];
  endfunction

  function automatic logic [31:0] read_reg(input int r);
    if (r == 0) return 32'd0;
    if (wb_en && int'(wb_addr) == r) return wb_data;
    return m_regs[r];
  endfunction

  function automatic bit model_ready();
    int rs, rt, d;
    bit rtype;
    rs = int'(instr[25:21]);
    rt = int'(instr[20:16]);
    d = dest_of(instr);
    rtype = (instr[31:26] == 6'd0);
    if (!rst) return 1'b0;
    if (m_valid && !ex_ready) return 1'b0;
    if (!instr_valid) return 1'b1;
    if (busy_now(rs) || (rtype && busy_now(rt)) || (d != 0 && busy_now(d))) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_valid = 0; m_opcode = 0; m_funct = 0; m_busA = 0; m_busB = 0; m_rd = 0;
  endtask

  initial model_clear();

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_clear();
    end else begin
      bit go;
      int d;
      go = instr_valid && model_ready();
      d = dest_of(instr);
      if (go) begin
        m_valid  = 1'b1;
        m_opcode = instr[31:26];
        m_funct  = instr[5:0];
        m_busA   = read_reg(int'(instr[25:21]));
        m_busB   = (instr[31:26] == 6'd0) ? read_reg(int'(instr[20:16]))
                                          : {{16{instr[15]}}, instr[15:0]};
        m_rd     = 5'(d);
      end else if (ex_ready) begin
        m_valid = 1'b0;
      end
      if (wb_en && wb_addr != 0) begin
        m_regs[wb_addr] = wb_data;
        m_busy[wb_addr] = 1'b0;
      end
      if (go && d != 0) m_busy[d] = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cmp_ready",  32'(instr_ready), 32'(model_ready()));
    chk("cmp_valid",  32'(ex_valid),    32'(m_valid));
    chk("cmp_opcode", 32'(ex_opcode),   32'(m_opcode));
    chk("cmp_funct",  32'(ex_funct),    32'(m_funct));
    chk("cmp_busA",   ex_busA,          m_busA);
    chk("cmp_busB",   ex_busB,          m_busB);
    chk("cmp_rd",     32'(ex_rd),       32'(m_rd));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset then idle
    tick(); tick();
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_busA", ex_busA, 32'd0);
    chk("rst_busB", ex_busB, 32'd0);
    chk("rst_ready_low", 32'(instr_ready), 32'd0);
    rst = 1'b1;
    #1 chk("idle_ready", 32'(instr_ready), 32'd1);

    // 2: preload r1=5, then addi r2,r1,-1
    wb_en = 1; wb_addr = 5'd1; wb_data = 32'd5;
    tick();
    wb_en = 0;
    instr_valid = 1; instr = 32'h2022FFFF;
    #1 chk("addi_ready", 32'(instr_ready), 32'd1);
    tick();
    instr_valid = 0;
    chk("addi_valid", 32'(ex_valid), 32'd1);
    chk("addi_opcode", 32'(ex_opcode), 32'h08);
    chk("addi_busA", ex_busA, 32'd5);
    chk("addi_busB", ex_busB, 32'hFFFFFFFF);
    chk("addi_rd", 32'(ex_rd), 32'd2);

    // 3: add r3,r2,r1 stalls on r2 until writeback bypass
    instr_valid = 1; instr = 32'h00411820;
    #1 chk("raw_stall0", 32'(instr_ready), 32'd0);
    tick();
    chk("raw_stall1", 32'(instr_ready), 32'd0);
    wb_en = 1; wb_addr = 5'd2; wb_data = 32'd4;
    #1 chk("raw_bypass_ready", 32'(instr_ready), 32'd1);
    tick();
    wb_en = 0; instr_valid = 0;
    chk("raw_valid", 32'(ex_valid), 32'd1);
    chk("raw_busA", ex_busA, 32'd4);
    chk("raw_busB", ex_busB, 32'd5);
    chk("raw_funct", 32'(ex_funct), 32'h20);
    chk("raw_rd", 32'(ex_rd), 32'd3);

    // 4: backpressure holds ex_* while addi r6,r1,7 waits
    ex_ready = 0;
    instr_valid = 1; instr = 32'h20260007;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready", 32'(instr_ready), 32'd0);
      tick();
      chk("bp_hold_rd", 32'(ex_rd), 32'd3);
      chk("bp_hold_busA", ex_busA, 32'd4);
    end
    ex_ready = 1;
    #1 chk("bp_release_ready", 32'(instr_ready), 32'd1);
    tick();
    instr_valid = 0;
    chk("bp_issue_rd", 32'(ex_rd), 32'd6);
    chk("bp_issue_busA", ex_busA, 32'd5);
    chk("bp_issue_busB", ex_busB, 32'd7);

    // 5: r0 ignores writes and never stalls
    wb_en = 1; wb_addr = 5'd0; wb_data = 32'hDEADBEEF;
    tick();
    wb_en = 0;
    instr_valid = 1; instr = 32'h00002020;
    #1 chk("r0_ready", 32'(instr_ready), 32'd1);
    tick();
    instr_valid = 0;
    chk("r0_busA", ex_busA, 32'd0);
    chk("r0_busB", ex_busB, 32'd0);
    chk("r0_rd", 32'(ex_rd), 32'd4);

    // 6: WAW on r5, cleared by an asynchronous reset pulse
    instr_valid = 1; instr = 32'h20050001;
    tick();
    instr = 32'h20050002;
    #1 chk("waw_ready", 32'(instr_ready), 32'd0);
    rst = 0;
    #1 chk("arst_valid", 32'(ex_valid), 32'd0);
    chk("arst_rd", 32'(ex_rd), 32'd0);
    rst = 1;
    #1 chk("arst_pend_clear", 32'(instr_ready), 32'd1);
    tick();
    instr_valid = 0;
    chk("waw_issue_valid", 32'(ex_valid), 32'd1);
    chk("waw_issue_busB", ex_busB, 32'd2);
    chk("waw_issue_rd", 32'(ex_rd), 32'd5);

    // Writeback during a stall to a non-pending register still lands
    ex_ready = 0;
    wb_en = 1; wb_addr = 5'd7; wb_data = 32'h1234_5678;
    tick();
    wb_en = 0; ex_ready = 1;
    instr_valid = 1; instr = 32'h00E73820;
    tick();
    instr_valid = 0;
    chk("wb_stall_busA", ex_busA, 32'h1234_5678);
    chk("wb_stall_busB", ex_busB, 32'h1234_5678);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
- Decode/register-read stage directly upstream of the ALU.
- Accepts 32-bit MIPS instructions over a valid/ready handshake and reads a 32-entry register file.
- Presents registered opcode, funct, busA, busB and destination to the ALU stage.
- Tracks in-flight destinations with a scoreboard, stalls on hazards, and receives writeback from downstream.

Parameters:
DATA_WIDTH, 32, register and bus width
REG_ADDR_WIDTH, 5, register index width; register count = 2**REG_ADDR_WIDTH

Ports:
clk  input  1  clock; all state on rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
instr_valid  input  1  instr holds a valid instruction
instr  input  32  instruction word
instr_ready  output  1  stage accepts instr this cycle
ex_valid  output  1  ex_* outputs hold an issued instruction
ex_ready  input  1  ALU stage consumes ex_* this cycle
ex_opcode  output  6  instr[31:26] of issued instruction
ex_funct  output  6  instr[5:0] of issued instruction
ex_busA  output  DATA_WIDTH  value of rs
ex_busB  output  DATA_WIDTH  rt value (R-type) or sign-extended imm[15:0] (all other opcodes)
ex_rd  output  REG_ADDR_WIDTH  destination register; 0 means no writeback
wb_en  input  1  writeback strobe
wb_addr  input  REG_ADDR_WIDTH  writeback register
wb_data  input  DATA_WIDTH  writeback value

Behaviour:
- Reset (rst=0, asynchronous):
  - all register-file entries, all scoreboard bits, ex_valid and every ex_* output go to 0.
  - instr_ready is 0 while reset is asserted.
- Field decode:
  - rs=instr[25:21], rt=instr[20:16], rd=instr[15:11], imm=instr[15:0].
  - imm is sign-extended to DATA_WIDTH.
- Destination selection:
  - opcode 000000 (R-type): dest=rd.
  - opcode 001000 (ADDI): dest=rt.
  - any other opcode: dest=0.
- Sources:
  - rs is always a source.
  - rt is a source only for R-type.
- Register 0:
  - reads as 0.
  - writes to it are ignored.
  - never marked pending.
- Effective pending for register r:
  - pend[r] AND NOT (wb_en AND wb_addr==r).
  - A same-cycle writeback clears the hazard.
- hazard = instr_valid AND any of:
  - rs is effectively pending;
  - R-type and rt is effectively pending;
  - dest!=0 and dest is effectively pending (WAW).
- Handshake:
  - slot_free = !ex_valid OR ex_ready.
  - instr_ready = slot_free AND !hazard. This is combinational on instr; permitted.
  - An issue occurs when instr_valid AND instr_ready.
- Issue timing:
  - On the issue edge, ex_* load the decoded fields and ex_valid=1.
  - Latency is 1 cycle from acceptance to ex_valid.
- When no issue occurs:
  - If ex_ready and ex_valid, ex_valid->0; the ex_* data holds its last value.
  - If !ex_ready, all ex_* hold (stall).
- Read bypass: if wb_en and wb_addr equals a source (non-zero) in the issue cycle, that bus takes wb_data instead of the array value.
- Writeback:
  - On the edge with wb_en and wb_addr!=0, regfile[wb_addr]<=wb_data.
  - pend[wb_addr] is cleared.
- Scoreboard update: pend_next = (pend with wb_addr cleared) | (issue AND dest!=0 ? onehot(dest) : 0).
  - Set wins when both target the same register.
  - A set on the same register as a same-cycle clear is only reachable via the effective-pending rule.
- Writebacks are accepted every cycle regardless of stall state.
  - A wb_en to a non-pending register still writes the register file.
- instr is sampled only on issue. Holding instr_valid with changing instr while not ready is allowed; it is treated as a new request.
- Reset mid-operation: in-flight ex_* data is discarded and the scoreboard is cleared immediately.

Test Plan:
1. Reset then idle:
   - Stimulus: rst=0 for 2 cycles, then rst=1 with instr_valid=0.
   - Required: ex_valid=0, ex_busA=ex_busB=0, and instr_ready=1 after rst deasserts.
2. ADDI issue:
   - Stimulus: preload r1=5 via wb, then issue instr=0x2022FFFF (addi r2,r1,-1).
   - Required: next cycle ex_valid=1, ex_opcode=001000, ex_busA=5, ex_busB=0xFFFFFFFF, ex_rd=2; pend[2]=1.
3. RAW stall:
   - Stimulus: after test 2, present add r3,r2,r1 (0x00411820).
   - Required: instr_ready=0 while pend[2]=1.
   - Stimulus: drive wb_en=1, wb_addr=2, wb_data=4.
   - Required: instr_ready=1 in that same cycle; the issued ex_busA=4 (bypass), ex_busB=5, ex_funct=100000, ex_rd=3.
4. Backpressure:
   - Stimulus: ex_ready=0 with ex_valid=1; offer a hazard-free instruction.
   - Required: instr_ready=0 and ex_* unchanged for 3 cycles.
   - Stimulus: ex_ready=1.
   - Required: the new instruction issues on that edge.
5. Register 0:
   - Stimulus: wb_en to r0 with data 0xDEADBEEF, then issue add r4,r0,r0.
   - Required: ex_busA=ex_busB=0; no stall from r0.
6. WAW plus async reset:
   - Stimulus: issue addi r5,r0,1, then offer addi r5,r0,2.
   - Required: instr_ready=0 (WAW).
   - Stimulus: pulse rst=0 mid-cycle.
   - Required: ex_valid=0 and pend cleared immediately; after release, the second addi issues with ex_busB=2.
